// File: rtl/pic_control_unit.sv
// 8259-style command/acknowledge controller: ICW/OCW decode, config outputs, INTA vector sequencing.
// Optional CPU status readback is compiled in with `define PIC_READBACK_EN.
module pic_control_unit #(
  parameter logic [7:0] VEC_RESET = 8'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] chosen_level,
  input  logic [7:0] irr_in,
  input  logic [7:0] isr_in,
  output logic       int_out,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic       level_or_edge_flag,
  output logic [7:0] mask,
  output logic       aeoi,
  output logic       eoi,
  output logic       rotate,
  output logic [1:0] intAcounter
);

  typedef enum logic [2:0] {UNINIT, ICW2, ICW3, ICW4, READY} init_st_t;

  init_st_t   st;
  logic       ic4, sngl;
  logic [4:0] base;
  logic [7:0] vec;
  logic       prev_wr_n, prev_inta_n;
  logic       wstb, icw1, inta_fall, inta_rise, ready;

  assign wstb      = !cs_n && !wr_n && prev_wr_n;
  assign icw1      = wstb && !a0 && din[4];
  assign inta_fall = !inta_n && prev_inta_n;
  assign inta_rise = inta_n && !prev_inta_n;
  assign ready     = (st == READY);

`ifdef PIC_READBACK_EN
  logic isr_sel;
`else
  logic unused_rb;
  assign unused_rb = ^{irr_in, isr_in, rd_n};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st                 <= UNINIT;
      ic4                <= 1'b0;
      sngl               <= 1'b0;
      base               <= VEC_RESET[7:3];
      vec                <= 8'h00;
      prev_wr_n          <= 1'b1;
      prev_inta_n        <= 1'b1;
      mask               <= 8'h00;
      level_or_edge_flag <= 1'b0;
      aeoi               <= 1'b0;
      eoi                <= 1'b0;
      rotate             <= 1'b0;
      intAcounter        <= 2'b00;
`ifdef PIC_READBACK_EN
      isr_sel            <= 1'b0;
`endif
    end else begin
      prev_wr_n   <= wr_n;
      prev_inta_n <= inta_n;
      eoi         <= 1'b0;
      if (icw1) begin
        // ICW1 restarts initialisation from any state and abandons any INTA cycle
        ic4                <= din[0];
        sngl               <= din[1];
        level_or_edge_flag <= din[3];
        mask               <= 8'h00;
        rotate             <= 1'b0;
        aeoi               <= 1'b0;
        intAcounter        <= 2'b00;
        st                 <= ICW2;
`ifdef PIC_READBACK_EN
        isr_sel            <= 1'b0;
`endif
      end else begin
        if (wstb && a0) begin
          case (st)
            ICW2: begin
              base <= din[7:3];
              st   <= !sngl ? ICW3 : (ic4 ? ICW4 : READY);
            end
            ICW3:    st <= ic4 ? ICW4 : READY;
            ICW4: begin
              aeoi <= din[1];
              st   <= READY;
            end
            READY:   mask <= din;
            default: ;
          endcase
        end else if (wstb && !a0 && ready) begin
          if (din[4:3] == 2'b00) begin
            case (din[7:5])
              3'b001:  eoi <= 1'b1;
              3'b101: begin
                eoi    <= 1'b1;
                rotate <= 1'b1;
              end
              3'b100:  rotate <= 1'b1;
              3'b000:  rotate <= 1'b0;
              default: ;
            endcase
          end else begin
`ifdef PIC_READBACK_EN
            if (din[1]) isr_sel <= din[0];
`endif
          end
        end
        if (ready) begin
          if (inta_fall) begin
            case (intAcounter)
              2'b00: intAcounter <= 2'b01;
              2'b01: begin
                intAcounter <= 2'b10;
                vec         <= {base, chosen_level};
              end
              default: ;
            endcase
          end
          if (inta_rise && intAcounter == 2'b10) intAcounter <= 2'b00;
        end
      end
    end
  end

  assign int_out = int_req && ready && (intAcounter == 2'b00);

  // Vector phase owns the bus; CPU reads only when no vector is being presented
  always_comb begin
    dout    = 8'h00;
    dout_en = 1'b0;
    if (intAcounter == 2'b10 && !inta_n) begin
      dout    = vec;
      dout_en = 1'b1;
    end
`ifdef PIC_READBACK_EN
    else if (!cs_n && !rd_n) begin
      dout_en = 1'b1;
      dout    = a0 ? mask : (isr_sel ? isr_in : irr_in);
    end
`endif
  end

endmodule
